// File: rtl/clk_div_prog_pkg.sv
// Shared clock-area definitions for the programmable divider: default field
// width, the smallest legal ratio and the ratio type used by integrators.
package clk_div_prog_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int MIN_DIV   = 2;

    typedef logic [DIV_W_DEF-1:0] div_t;

endpackage : clk_div_prog_pkg

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable divider. The master side requests
// ratios and gates counting; the slave side (the divider) reports its outputs.
interface clk_div_prog_if
    import clk_div_prog_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);

    logic             en;
    logic             load;
    logic [DIV_W-1:0] div;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] active_div;
    logic             pending;

    modport master (
        output en,
        output load,
        output div,
        input  clk_out,
        input  tick,
        input  active_div,
        input  pending
    );

    modport slave (
        input  en,
        input  load,
        input  div,
        output clk_out,
        output tick,
        output active_div,
        output pending
    );

endinterface : clk_div_prog_if

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: registered clk_out with ceil(N/2) high
// cycles, a tick strobe on each rising edge, and glitch-free ratio changes.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int RST_DIV = MIN_DIV
) (
    input  logic          clk_in,
    input  logic          rst_n,
    clk_div_prog_if.slave bus
);

    localparam logic [DIV_W-1:0] ONE_V     = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);

    // Ratios 0 and 1 cannot form a period with both phases, so they become 2.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        logic [DIV_W-1:0] r;
        if (d < MIN_DIV_V) begin
            r = MIN_DIV_V;
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] active_div_r;
    logic [DIV_W-1:0] pend_div_r;
    logic             pending_r;
    logic             clk_out_r;
    logic             tick_r;

    logic [DIV_W:0]   high_len_s;
    logic [DIV_W-1:0] cnt_inc_s;
    logic             wrap_s;
    logic             fall_s;
    logic [DIV_W-1:0] load_div_s;

    // Period bookkeeping derived from the ratio currently in force.
    always_comb begin
        high_len_s = ({1'b0, active_div_r} + {1'b0, ONE_V}) >> 1;
        cnt_inc_s  = cnt_r + ONE_V;
        wrap_s     = (cnt_r == (active_div_r - ONE_V));
        fall_s     = ({1'b0, cnt_inc_s} == high_len_s);
        load_div_s = clamp_div(bus.div);
    end

    // Counter, phase output, strobe and ratio shadowing.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= {DIV_W{1'b0}};
            active_div_r <= RST_DIV_V;
            pend_div_r   <= RST_DIV_V;
            pending_r    <= 1'b0;
            clk_out_r    <= 1'b0;
            tick_r       <= 1'b0;
        end else begin
            if (bus.en && wrap_s) begin
                cnt_r     <= {DIV_W{1'b0}};
                clk_out_r <= 1'b1;
                tick_r    <= 1'b1;
                // A load landing on the wrap edge skips the shadow register.
                if (bus.load) begin
                    active_div_r <= load_div_s;
                    pending_r    <= 1'b0;
                end else if (pending_r) begin
                    active_div_r <= pend_div_r;
                    pending_r    <= 1'b0;
                end else begin
                    active_div_r <= active_div_r;
                    pending_r    <= pending_r;
                end
            end else begin
                if (bus.en) begin
                    cnt_r <= cnt_inc_s;
                    if (fall_s) begin
                        clk_out_r <= 1'b0;
                    end else begin
                        clk_out_r <= clk_out_r;
                    end
                end else begin
                    cnt_r     <= cnt_r;
                    clk_out_r <= clk_out_r;
                end
                tick_r <= 1'b0;
                if (bus.load) begin
                    pend_div_r <= load_div_s;
                    pending_r  <= 1'b1;
                end else begin
                    pend_div_r <= pend_div_r;
                    pending_r  <= pending_r;
                end
            end
        end
    end

    assign bus.clk_out    = clk_out_r;
    assign bus.tick       = tick_r;
    assign bus.active_div = active_div_r;
    assign bus.pending    = pending_r;

endmodule : clk_div_prog

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed vector table, hand-written
// corner sequences, then randomized traffic against a phase-position model.
module tb_clk_div_prog;
    import clk_div_prog_pkg::*;

    typedef struct {
        bit   en;
        bit   load;
        div_t div;
        bit   e_clk;
        bit   e_tick;
        div_t e_act;
        bit   e_pend;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    clk_div_prog_if #(.DIV_W(8)) bus ();

    clk_div_prog #(.DIV_W(8), .RST_DIV(2)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit e, input bit l, input div_t d);
        bus.en   = e;
        bus.load = l;
        bus.div  = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: position within the current period and the ratio in force.
    int m_n, m_pend_n, m_pos;
    bit m_first, m_pend, m_tick;

    task automatic model_reset();
        m_n = 2; m_pend_n = 2; m_pos = 0;
        m_first = 1'b1; m_pend = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit l, input int d);
        int c;
        bit boundary;
        c = (d < 2) ? 2 : d;
        boundary = e && (m_pos + 1 == m_n);
        m_tick = boundary;
        if (boundary) begin
            m_pos = 0;
            m_first = 1'b0;
            if (l) begin
                m_n = c;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_n = m_pend_n;
                m_pend = 1'b0;
            end
        end else if (e) begin
            m_pos = m_pos + 1;
        end
        if (l && !boundary) begin
            m_pend_n = c;
            m_pend = 1'b1;
        end
    endtask

    function automatic bit model_clk();
        return !m_first && (m_pos < (m_n + 1) / 2);
    endfunction

    vec_t vecs [24];
    int   hi, ee;
    bit   found;
    bit   r_en, r_ld;
    div_t r_div;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.div = 8'd0;

        vecs = '{
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0},
            '{1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 8'd2, 1'b1},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b0},
            '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd5, 1'b1},
            '{1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 8'd5, 1'b1},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b1},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0},
            '{1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 8'd4, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b0},
            '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b0}
        };

        #12;
        chk("reset_clk_out", bus.clk_out, 0);
        chk("reset_tick", bus.tick, 0);
        chk("reset_active_div", bus.active_div, 2);
        chk("reset_pending", bus.pending, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: N=2 phase, load 5 mid-period, clamped loads, load on wrap.
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].en, vecs[i].load, vecs[i].div);
            chk($sformatf("vec%0d_clk_out", i), bus.clk_out, vecs[i].e_clk);
            chk($sformatf("vec%0d_tick", i), bus.tick, vecs[i].e_tick);
            chk($sformatf("vec%0d_active_div", i), bus.active_div, vecs[i].e_act);
            chk($sformatf("vec%0d_pending", i), bus.pending, vecs[i].e_pend);
        end

        // N=6 with a 7-cycle enable drop inside the high phase.
        step(1'b1, 1'b1, 8'd6);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 8'd0);
            if (bus.tick && bus.active_div == 8'd6) found = 1'b1;
        end
        chk("n6_boundary_reached", found, 1);
        hi = 1;
        ee = 1;
        step(1'b1, 1'b0, 8'd0);
        hi += bus.clk_out;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 8'd0);
            chk("en_low_hold_clk_out", bus.clk_out, 1);
            chk("en_low_tick", bus.tick, 0);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 8'd0);
            ee++;
            if (bus.tick) found = 1'b1;
            else hi += bus.clk_out;
        end
        chk("en_drop_next_tick", found, 1);
        chk("en_drop_period_cycles", ee, 6);
        chk("en_drop_high_cycles", hi, 3);

        // Asynchronous reset while high with a ratio pending.
        step(1'b1, 1'b1, 8'd9);
        bus.load = 1'b0;
        chk("pre_reset_clk_out", bus.clk_out, 1);
        chk("pre_reset_pending", bus.pending, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clk_out", bus.clk_out, 0);
        chk("async_reset_tick", bus.tick, 0);
        chk("async_reset_active_div", bus.active_div, 2);
        chk("async_reset_pending", bus.pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        chk("post_reset_tick", bus.tick, 1);
        chk("post_reset_active_div", bus.active_div, 2);
        chk("post_reset_pending", bus.pending, 0);

        // Randomized traffic against the model, from a fresh reset.
        #3;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            r_en  = ($urandom_range(0, 9) != 0);
            r_ld  = ($urandom_range(0, 11) == 0);
            r_div = div_t'($urandom_range(0, 12));
            model_step(r_en, r_ld, int'(r_div));
            step(r_en, r_ld, r_div);
            chk("rand_clk_out", bus.clk_out, model_clk());
            chk("rand_tick", bus.tick, m_tick);
            chk("rand_active_div", bus.active_div, m_n);
            chk("rand_pending", bus.pending, m_pend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_clk_div_prog
